// File: rtl/palindrome_arbiter.sv
// palindrome_arbiter: round-robin front end for one shared serial palindrome checker.
// A granted word is checked one mirrored bit pair per cycle, from the outside
// pair inward. The check stops at the first mismatching pair. The result is
// returned as a tagged, one-cycle response.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; req_ready is driven for the RR winner
// CHECK | comparing word[WIDTH-1-idx] against word[idx], one pair/cycle
// DONE  | resp_valid high for one cycle; resp_id/resp_palindrome valid
module palindrome_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  output logic [ID_W-1:0]            resp_id,
  output logic                       resp_palindrome,
  output logic                       busy
);

  // IDX_W stays at least 1 bit wide, even when WIDTH == 2.
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_PAIR = IDX_W'(WIDTH/2 - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] word;
  logic [IDX_W-1:0] idx;
  logic [ID_W-1:0]  cur_id;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  sel;
  logic             any_req;

  // Round-robin search: the first valid requester after last_grant, with wrap-around.
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!any_req && req_valid[(int'(last_grant) + off) % NUM_REQ]) begin
        any_req = 1'b1;
        sel     = ID_W'((int'(last_grant) + off) % NUM_REQ);
      end
    end
  end

  // Grant strobe. It only exists in IDLE, so its only input path is req_valid.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state == IDLE) && any_req && (sel == ID_W'(i));
    end
  end

  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  // Sequencer: capture on grant, walk the pairs inward, publish the result on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      word            <= '0;
      idx             <= '0;
      cur_id          <= '0;
      last_grant      <= ID_W'(NUM_REQ - 1);
      resp_id         <= '0;
      resp_palindrome <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            word       <= req_data[int'(sel)*WIDTH +: WIDTH];
            cur_id     <= sel;
            last_grant <= sel;
            idx        <= '0;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (word[WIDTH-1-int'(idx)] != word[idx]) begin
            resp_palindrome <= 1'b0;
            resp_id         <= cur_id;
            state           <= DONE;
          end else if (idx == LAST_PAIR) begin
            resp_palindrome <= 1'b1;
            resp_id         <= cur_id;
            state           <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palindrome_arbiter.sv
// Directed bench for palindrome_arbiter with NUM_REQ=4 and WIDTH=8.
// Inputs change on the falling edge; outputs are sampled away from the rising edge.
module tb_palindrome_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic        resp_palindrome;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  palindrome_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_id         (resp_id),
    .resp_palindrome (resp_palindrome),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Starts at a falling edge while the DUT is idle. Returns on the falling edge after the response.
  task automatic run_req(input logic [3:0] mask, input int gid, input logic [7:0] word,
                         input logic exp_pal, input int exp_lat);
    logic [3:0] exp_rdy;
    int lat;
    logic got;
    exp_rdy = 4'b0001 << gid;
    req_data[gid*8 +: 8] = word;
    req_valid = mask;
    #1;
    check("grant", req_ready, exp_rdy);
    check("idle_busy", busy, 0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      req_valid = '0;
      if (lat == 1) check("busy_after_accept", busy, 1);
      if (resp_valid) got = 1'b1;
    end
    check("resp_seen", got, 1);
    check("latency", lat, exp_lat);
    check("resp_id", resp_id, gid);
    check("resp_pal", resp_palindrome, exp_pal);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 0);
    check("back_idle", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_rdy;
    int viol;
    int lat;
    logic got;
    logic [1:0] rr_id;
    logic rr_pal [4];

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    #12;
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_pal", resp_palindrome, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single requester: full palindrome, then early exits at each pair position.
    run_req(4'b0001, 0, 8'b1000_0001, 1'b1, 5);
    run_req(4'b0100, 2, 8'b1000_0000, 1'b0, 2);
    run_req(4'b0010, 1, 8'b0001_0000, 1'b0, 5);
    run_req(4'b1000, 3, 8'b0001_1000, 1'b1, 5);
    run_req(4'b0001, 0, 8'b0100_0000, 1'b0, 3);
    run_req(4'b0010, 1, 8'b0000_0100, 1'b0, 4);
    run_req(4'b0100, 2, 8'b0101_1010, 1'b1, 5);
    run_req(4'b1000, 3, 8'b0000_0000, 1'b1, 5);

    // Round robin starting from a fresh pointer: the order must be 0,1,2,3,0.
    do_reset();
    req_data = {8'b0000_0001, 8'b0001_1000, 8'b1000_0000, 8'b1000_0001};
    rr_pal[0] = 1'b1; rr_pal[1] = 1'b0; rr_pal[2] = 1'b1; rr_pal[3] = 1'b0;
    req_valid = 4'b1111;
    #1;
    viol = 0;
    for (int g = 0; g < 5; g++) begin
      rr_id = 2'(g % 4);
      exp_rdy = 4'b0001 << rr_id;
      check("rr_grant", req_ready, exp_rdy);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
        @(negedge clk);
        lat++;
        if (busy && req_ready != 4'b0000) viol++;
        if (resp_valid) got = 1'b1;
      end
      check("rr_resp_seen", got, 1);
      check("rr_resp_id", resp_id, rr_id);
      check("rr_resp_pal", resp_palindrome, rr_pal[rr_id]);
      if (g == 4) req_valid = '0;
      @(negedge clk);
      #1;
    end
    check("rr_ready_while_busy", viol, 0);
    check("rr_drained", busy, 0);

    // Reset during CHECK drops the job; afterwards the pointer favours requester 1 over 3.
    @(negedge clk);
    run_req(4'b0100, 2, 8'b1000_0001, 1'b1, 5);
    req_data[15:8] = 8'b1111_1111;
    req_valid = 4'b0010;
    #1;
    check("mid_grant", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_resp_valid", resp_valid, 0);
    check("async_resp_id", resp_id, 0);
    check("async_resp_pal", resp_palindrome, 0);
    check("async_ready", req_ready, 0);
    viol = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid || busy) viol++;
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid || busy) viol++;
    end
    check("no_stale_resp", viol, 0);
    run_req(4'b1010, 1, 8'b1111_1111, 1'b1, 5);

    // Requester 3 pulses valid while the engine is busy and must never be served.
    req_data[7:0] = 8'b1000_0001;
    req_valid = 4'b0001;
    #1;
    check("pulse_grant0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    check("pulse_no_ready", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    lat = 2;
    got = resp_valid;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) got = 1'b1;
    end
    check("pulse_resp_seen", got, 1);
    check("pulse_latency", lat, 5);
    check("pulse_resp_id", resp_id, 0);
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid || busy || req_ready != 4'b0000) viol++;
    end
    check("pulse_never_served", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
